// File: rtl/window_scheduler.sv
// Register-window sequencer: tracks CWP across call/return and drives the register file window select.
// Spill/fill of windows to data memory is built only when WINDOW_SPILL_EN is defined.
module window_scheduler #(
  parameter int              NWIN       = 4,
  parameter int              NREG       = 4,
  parameter int              ADDR_W     = 8,
  parameter logic [ADDR_W-1:0] SPILL_BASE = 8'h80,
  parameter int              MAX_SPILL  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      op_valid,
  input  logic                      op_call,
  output logic                      op_ready,
  output logic                      op_done,
  output logic                      op_err,
  output logic [$clog2(NWIN)-1:0]   cwp,
  output logic [$clog2(NWIN)-1:0]   rf_window,
  output logic [$clog2(NREG)-1:0]   rf_rd_reg,
  input  logic [15:0]               rf_rd_data,
  output logic                      rf_wr_en,
  output logic [$clog2(NREG)-1:0]   rf_wr_reg,
  output logic [15:0]               rf_wr_data,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [15:0]               mem_wdata,
  input  logic [15:0]               mem_rdata,
  input  logic                      mem_ack
);

  localparam int WW = $clog2(NWIN);
  localparam int RW = $clog2(NREG);
  localparam int CW = $clog2(NWIN + 1);
  localparam int SW = $clog2(MAX_SPILL + 1);

  localparam logic [CW-1:0] RES_ONE  = CW'(1);
  localparam logic [CW-1:0] RES_MAX  = CW'(NWIN);
  localparam logic [SW-1:0] SP_MAX   = SW'(MAX_SPILL);
  localparam logic [RW-1:0] IDX_LAST = RW'(NREG - 1);

`ifdef WINDOW_SPILL_EN
  localparam bit SPILL_EN = 1'b1;
`else
  localparam bit SPILL_EN = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, SEL, RD, MWR, MRD, WR, RESTORE} state_t;
  state_t state, state_nx;

  logic [CW-1:0]     res;
  logic [SW-1:0]     sp;
  logic [SW-1:0]     slot;
  logic [WW-1:0]     tgt;
  logic [RW-1:0]     idx;
  logic [15:0]       data;
  logic              spill_dir;
  logic              done_q;
  logic              err_q;
  logic              go_fast, go_spill, go_fill, reject;
  logic              mem_req_c, rf_wr_en_c;
  logic [ADDR_W-1:0] slot_addr;

  assign slot_addr = SPILL_BASE + ADDR_W'(slot) * ADDR_W'(NREG) + ADDR_W'(idx);

  always_comb begin
    go_fast  = 1'b0;
    go_spill = 1'b0;
    go_fill  = 1'b0;
    if (state == IDLE && op_valid) begin
      if (op_call) begin
        if (res != RES_MAX)                go_fast  = 1'b1;
        else if (SPILL_EN && sp != SP_MAX) go_spill = 1'b1;
      end else begin
        if (res != RES_ONE)                go_fast  = 1'b1;
        else if (SPILL_EN && sp != '0)     go_fill  = 1'b1;
      end
    end
  end

  assign reject = (state == IDLE) && op_valid && !go_fast && !go_spill && !go_fill;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // tgt holds the window being moved, which is also the CWP once the move completes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cwp       <= '0;
      res       <= RES_ONE;
      sp        <= '0;
      slot      <= '0;
      tgt       <= '0;
      idx       <= '0;
      data      <= '0;
      spill_dir <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (go_fast) begin
            done_q <= 1'b1;
            if (op_call) begin
              cwp <= cwp + WW'(1);
              res <= res + CW'(1);
            end else begin
              cwp <= cwp - WW'(1);
              res <= res - CW'(1);
            end
          end
          if (reject) begin
            done_q <= 1'b1;
            err_q  <= 1'b1;
          end
          if (go_spill) begin
            tgt       <= cwp + WW'(1);
            slot      <= sp;
            idx       <= '0;
            spill_dir <= 1'b1;
          end
          if (go_fill) begin
            tgt       <= cwp - WW'(1);
            slot      <= sp - SW'(1);
            idx       <= '0;
            spill_dir <= 1'b0;
          end
        end
        RD:  data <= rf_rd_data;
        MWR: if (mem_ack) begin
          if (idx == IDX_LAST) begin
            cwp <= tgt;
            sp  <= sp + SW'(1);
          end else begin
            idx <= idx + RW'(1);
          end
        end
        MRD: if (mem_ack) data <= mem_rdata;
        WR: begin
          if (idx == IDX_LAST) begin
            cwp <= tgt;
            sp  <= sp - SW'(1);
          end else begin
            idx <= idx + RW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx   = state;
    rf_window  = cwp;
    rf_rd_reg  = '0;
    mem_req_c  = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    rf_wr_en_c = 1'b0;
    rf_wr_reg  = '0;
    rf_wr_data = '0;
    case (state)
      IDLE: if (go_spill || go_fill) state_nx = SEL;
      SEL: begin
        rf_window = tgt;
        state_nx  = spill_dir ? RD : MRD;
      end
      RD: begin
        rf_window = tgt;
        rf_rd_reg = idx;
        state_nx  = MWR;
      end
      MWR: begin
        rf_window = tgt;
        mem_req_c = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = slot_addr;
        mem_wdata = data;
        if (mem_ack) state_nx = (idx == IDX_LAST) ? RESTORE : RD;
      end
      MRD: begin
        rf_window = tgt;
        mem_req_c = 1'b1;
        mem_addr  = slot_addr;
        if (mem_ack) state_nx = WR;
      end
      WR: begin
        rf_window  = tgt;
        rf_wr_en_c = 1'b1;
        rf_wr_reg  = idx;
        rf_wr_data = data;
        state_nx   = (idx == IDX_LAST) ? RESTORE : MRD;
      end
      RESTORE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

`ifdef WINDOW_SPILL_EN
  assign mem_req  = mem_req_c;
  assign rf_wr_en = rf_wr_en_c;
`else
  assign mem_req  = 1'b0;
  assign rf_wr_en = 1'b0;
`endif

  assign op_ready = (state == IDLE);
  assign op_done  = done_q || (state == RESTORE);
  assign op_err   = err_q;

endmodule
